// File: rtl/mult_div_if.sv
// Handshake and result bundle between the main control unit and the MULT/DIV sequencer.
interface mult_div_if #(parameter int WIDTH = 32);
    logic             start_mult;
    logic             start_div;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             div_zero;

    modport master (
        output start_mult, start_div, a, b,
        input  hi, lo, busy, done, div_zero
    );

    modport slave (
        input  start_mult, start_div, a, b,
        output hi, lo, busy, done, div_zero
    );
endinterface

// File: rtl/mult_div_ctrl.sv
// Multi-cycle signed multiply / restoring divide sequencer writing HI and LO.
// Operands are reduced to magnitudes on acceptance and the sign is restored in FIX.
module mult_div_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        reset,
    mult_div_if.slave   bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0]   ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0] ONE_2W = {{(2*WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MULT_RUN = 2'd1,
        DIV_RUN  = 2'd2,
        FIX      = 2'd3
    } state_t;

    state_t             state_r;
    logic [CW-1:0]      cnt_r;
    logic [WIDTH-1:0]   mag_a_r;
    logic [WIDTH-1:0]   mag_b_r;
    logic [2*WIDTH-1:0] acc_r;
    logic [WIDTH:0]     rem_r;
    logic [WIDTH-1:0]   quo_r;
    logic               sign_r;
    logic               qsign_r;
    logic               rsign_r;
    logic               is_div_r;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;
    logic               busy_r;
    logic               done_r;
    logic               div_zero_r;

    logic [2*WIDTH-1:0] addend_s;
    logic [WIDTH:0]     rem_sh_s;
    logic [WIDTH:0]     diff_s;

    // Magnitudes are unsigned, so the most negative value maps to itself exactly.
    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? ((~v) + ONE_W) : v;
    endfunction

    // One shift-add partial product and one restoring trial subtraction per cycle.
    always_comb begin
        addend_s = {(2*WIDTH){1'b0}};
        if (mag_b_r[cnt_r]) begin
            addend_s = {{WIDTH{1'b0}}, mag_a_r} << cnt_r;
        end else begin
            addend_s = {(2*WIDTH){1'b0}};
        end
        rem_sh_s = {rem_r[WIDTH-1:0], quo_r[WIDTH-1]};
        diff_s   = rem_sh_s - {1'b0, mag_b_r};
    end

    // Sequencer state, datapath registers and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= IDLE;
            cnt_r      <= {CW{1'b0}};
            mag_a_r    <= {WIDTH{1'b0}};
            mag_b_r    <= {WIDTH{1'b0}};
            acc_r      <= {(2*WIDTH){1'b0}};
            rem_r      <= {(WIDTH+1){1'b0}};
            quo_r      <= {WIDTH{1'b0}};
            sign_r     <= 1'b0;
            qsign_r    <= 1'b0;
            rsign_r    <= 1'b0;
            is_div_r   <= 1'b0;
            hi_r       <= {WIDTH{1'b0}};
            lo_r       <= {WIDTH{1'b0}};
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            div_zero_r <= 1'b0;
        end else begin
            done_r     <= 1'b0;
            div_zero_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (bus.start_mult) begin
                        mag_a_r  <= abs_val(bus.a);
                        mag_b_r  <= abs_val(bus.b);
                        sign_r   <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
                        acc_r    <= {(2*WIDTH){1'b0}};
                        cnt_r    <= {CW{1'b0}};
                        is_div_r <= 1'b0;
                        busy_r   <= 1'b1;
                        state_r  <= MULT_RUN;
                    end else if (bus.start_div && (bus.b == {WIDTH{1'b0}})) begin
                        div_zero_r <= 1'b1;
                    end else if (bus.start_div) begin
                        mag_a_r  <= abs_val(bus.a);
                        mag_b_r  <= abs_val(bus.b);
                        qsign_r  <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
                        rsign_r  <= bus.a[WIDTH-1];
                        rem_r    <= {(WIDTH+1){1'b0}};
                        quo_r    <= abs_val(bus.a);
                        cnt_r    <= {CW{1'b0}};
                        is_div_r <= 1'b1;
                        busy_r   <= 1'b1;
                        state_r  <= DIV_RUN;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                MULT_RUN: begin
                    acc_r <= acc_r + addend_s;
                    cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
                    if (cnt_r == CW'(WIDTH-1)) begin
                        state_r <= FIX;
                    end else begin
                        state_r <= MULT_RUN;
                    end
                end
                DIV_RUN: begin
                    // A clear borrow bit means the trial subtraction fits.
                    if (!diff_s[WIDTH]) begin
                        rem_r <= diff_s;
                        quo_r <= {quo_r[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_r <= rem_sh_s;
                        quo_r <= {quo_r[WIDTH-2:0], 1'b0};
                    end
                    cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
                    if (cnt_r == CW'(WIDTH-1)) begin
                        state_r <= FIX;
                    end else begin
                        state_r <= DIV_RUN;
                    end
                end
                FIX: begin
                    if (is_div_r) begin
                        lo_r <= qsign_r ? ((~quo_r) + ONE_W) : quo_r;
                        hi_r <= rsign_r ? ((~rem_r[WIDTH-1:0]) + ONE_W) : rem_r[WIDTH-1:0];
                    end else begin
                        {hi_r, lo_r} <= sign_r ? ((~acc_r) + ONE_2W) : acc_r;
                    end
                    done_r  <= 1'b1;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.hi       = hi_r;
    assign bus.lo       = lo_r;
    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.div_zero = div_zero_r;
endmodule
